// File: rtl/fir_mac_sequencer.sv
// Sequential single-MAC FIR filter with valid/ready streaming ports and writable coefficients.
// Define FIR_SEQ_OVF_FLAG_EN to add the sticky saturation flag output ovf.
module fir_mac_sequencer #(
    parameter int NTAPS = 4,
    parameter int W     = 16
) (
    input  logic                     system1000,
    input  logic                     system1000_rst,
    input  logic                     in_valid,
    input  logic signed [W-1:0]      in_data,
    output logic                     in_ready,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic signed [W-1:0]      coef_data,
    output logic                     out_valid,
    output logic signed [W-1:0]      out_data,
    input  logic                     out_ready
`ifdef FIR_SEQ_OVF_FLAG_EN
    ,
    output logic                     ovf
`endif
);
    localparam int AW = $clog2(NTAPS);
    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic signed [2*W-1:0] mul_full(input logic signed [W-1:0] a,
                                                       input logic signed [W-1:0] b);
        logic signed [2*W-1:0] ae;
        logic signed [2*W-1:0] be;
        ae = {{W{a[W-1]}}, a};
        be = {{W{b[W-1]}}, b};
        return ae * be;
    endfunction

    // The shifted product fits in W bits only when its top W+1 bits are a pure sign extension.
    function automatic logic sat_q_ovf(input logic signed [2*W-1:0] p);
        logic signed [2*W-1:0] s;
        s = p >>> (W-1);
        return (s[2*W-1:W-1] != {(W+1){s[2*W-1]}});
    endfunction

    function automatic logic signed [W-1:0] sat_q(input logic signed [2*W-1:0] p);
        logic signed [2*W-1:0] s;
        s = p >>> (W-1);
        if (s[2*W-1:W-1] == {(W+1){s[2*W-1]}}) begin
            return s[W-1:0];
        end else if (s[2*W-1]) begin
            return MIN_V;
        end else begin
            return MAX_V;
        end
    endfunction

    function automatic logic sat_add_ovf(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [W-1:0] s;
        s = a + b;
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic signed [W-1:0] s;
        s = a + b;
        if ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1])) begin
            return a[W-1] ? MIN_V : MAX_V;
        end else begin
            return s;
        end
    endfunction

    state_t                r_state;
    logic [AW-1:0]         r_idx;
    logic                  r_drain;
    logic signed [W-1:0]   r_acc;
    logic signed [W-1:0]   r_prod;
    logic signed [W-1:0]   r_x [NTAPS];
    logic signed [W-1:0]   r_c [NTAPS];
    logic signed [2*W-1:0] w_prod;

    assign w_prod    = mul_full(r_x[r_idx], r_c[r_idx]);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_acc;

    // Product is registered one cycle ahead of the accumulate, so ACCUM ends with one drain cycle.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_drain <= 1'b0;
            r_acc   <= '0;
            r_prod  <= '0;
            for (int k = 0; k < NTAPS; k++) begin
                r_x[k] <= '0;
                r_c[k] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    for (int k = 0; k < NTAPS; k++) begin
                        if (coef_we && (coef_addr == AW'(k))) begin
                            r_c[k] <= coef_data;
                        end
                    end
                    if (in_valid) begin
                        r_x[0] <= in_data;
                        for (int k = 1; k < NTAPS; k++) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_acc   <= '0;
                        r_prod  <= '0;
                        r_idx   <= '0;
                        r_drain <= 1'b0;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_acc <= sat_add(r_acc, r_prod);
                    if (r_drain) begin
                        r_state <= DONE;
                    end else begin
                        r_prod <= sat_q(w_prod);
                        if (r_idx == AW'(NTAPS-1)) begin
                            r_drain <= 1'b1;
                        end else begin
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef FIR_SEQ_OVF_FLAG_EN
    logic r_ovf;

    assign ovf = r_ovf;

    // Sticky clamp flag, cleared only by reset.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            r_ovf <= 1'b0;
        end else if ((r_state == ACCUM) &&
                     (sat_add_ovf(r_acc, r_prod) || (!r_drain && sat_q_ovf(w_prod)))) begin
            r_ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: vector table, directed corner sequences and
// randomized samples compared against an arithmetic reference model.
module tb_fir_mac_sequencer;
    localparam int NTAPS = 4;
    localparam int W     = 16;
    localparam int MAXI  = 32767;
    localparam int MINI  = -32768;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic signed [W-1:0] in_data;
    logic                in_ready;
    logic                coef_we;
    logic [1:0]          coef_addr;
    logic signed [W-1:0] coef_data;
    logic                out_valid;
    logic signed [W-1:0] out_data;
    logic                out_ready;
`ifdef FIR_SEQ_OVF_FLAG_EN
    logic                ovf;
`endif

    int checks = 0;
    int errors = 0;
    int xm [NTAPS];
    int cm [NTAPS];
    bit m_ovf;

    typedef struct {
        logic signed [W-1:0] c0;
        logic signed [W-1:0] c1;
        logic signed [W-1:0] s0;
        logic signed [W-1:0] s1;
        logic signed [W-1:0] expv;
    } vec_t;
    vec_t vt [7];

    fir_mac_sequencer #(.NTAPS(NTAPS), .W(W)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .coef_we        (coef_we),
        .coef_addr      (coef_addr),
        .coef_data      (coef_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready)
`ifdef FIR_SEQ_OVF_FLAG_EN
        ,
        .ovf            (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic ref_v);
        checks++;
        if (act !== ref_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, ref_v, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] ref_v);
        checks++;
        if (act !== ref_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, ref_v, $time);
        end
    endtask

    // Reference arithmetic: exact product, floor-divide by 2^15, clamp to the Q15 range.
    function automatic int m_satq(input int a, input int b);
        longint p;
        longint q;
        p = longint'(a) * longint'(b);
        q = p >>> 15;
        if (q > MAXI) begin
            m_ovf = 1'b1;
            return MAXI;
        end
        if (q < MINI) begin
            m_ovf = 1'b1;
            return MINI;
        end
        return int'(q);
    endfunction

    function automatic int m_satadd(input int a, input int b);
        int s;
        s = a + b;
        if (s > MAXI) begin
            m_ovf = 1'b1;
            return MAXI;
        end
        if (s < MINI) begin
            m_ovf = 1'b1;
            return MINI;
        end
        return s;
    endfunction

    function automatic int m_result();
        int acc;
        acc = 0;
        for (int k = 0; k < NTAPS; k++) acc = m_satadd(acc, m_satq(xm[k], cm[k]));
        return acc;
    endfunction

    function automatic void m_clear();
        for (int k = 0; k < NTAPS; k++) begin
            xm[k] = 0;
            cm[k] = 0;
        end
        m_ovf = 1'b0;
    endfunction

    function automatic logic signed [W-1:0] rnd16();
        logic signed [W-1:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 1) == 1) v = v >>> 3;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        coef_we = 1'b0;
        out_ready = 1'b0;
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk16("rst_out_data", out_data, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        m_clear();
    endtask

    task automatic write_coef(input logic [1:0] a, input logic signed [W-1:0] v);
        @(negedge clk);
        coef_we = 1'b1;
        coef_addr = a;
        coef_data = v;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        cm[a] = int'(v);
    endtask

    // One full transaction: accept, NTAPS+1 busy edges, optional backpressure, then handshake.
    task automatic run_sample(input logic signed [W-1:0] d, input int hold, input bit we_acpt,
                              input bit we_acc, input logic [1:0] wa, input logic signed [W-1:0] wd,
                              output logic signed [W-1:0] got);
        int expv;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = d;
        chk1("accept_ready", in_ready, 1'b1);
        if (we_acpt) begin
            coef_we = 1'b1;
            coef_addr = wa;
            coef_data = wd;
        end
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        if (we_acpt) cm[wa] = int'(wd);
        for (int k = NTAPS - 1; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = int'(d);
        expv = m_result();
        for (int k = 0; k <= NTAPS + 1; k++) begin
            @(negedge clk);
            in_data = rnd16();
            coef_we = 1'b0;
            if (we_acc && k == 2) begin
                coef_we = 1'b1;
                coef_addr = wa;
                coef_data = wd;
            end
            if (k <= NTAPS) begin
                chk1("busy_valid", out_valid, 1'b0);
                chk1("busy_ready", in_ready, 1'b0);
            end else begin
                chk1("done_valid", out_valid, 1'b1);
                chk16("result", out_data, 16'(expv));
            end
        end
        coef_we = 1'b0;
        got = out_data;
`ifdef FIR_SEQ_OVF_FLAG_EN
        chk1("ovf_flag", ovf, m_ovf);
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_data = rnd16();
            chk16("hold_stable", out_data, 16'(expv));
            chk1("hold_valid", out_valid, 1'b1);
            chk1("hold_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk1("back_idle", in_ready, 1'b1);
        chk1("back_valid", out_valid, 1'b0);
    endtask

    initial begin
        logic signed [W-1:0] got;
        int nw;
        bit seen;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        coef_we = 1'b0;
        coef_addr = 2'd0;
        coef_data = '0;
        out_ready = 1'b0;
        m_clear();

        vt[0] = '{16'sh4000, 16'sh4000, 16'sh1000, 16'sh1000, 16'sh1000};
        vt[1] = '{16'sh8000, 16'sh0000, 16'sh0000, 16'sh8000, 16'sh7FFF};
        vt[2] = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF};
        vt[3] = '{16'sh8000, 16'sh8000, 16'sh7FFF, 16'sh7FFF, 16'sh8000};
        vt[4] = '{16'shC000, 16'sh2000, 16'sh4000, 16'sh2000, 16'sh0000};
        vt[5] = '{16'sh0001, 16'sh0000, 16'sh0000, 16'shFFFF, 16'shFFFF};
        vt[6] = '{16'sh4000, 16'shC000, 16'sh6000, 16'sh2000, 16'shE000};

        repeat (2) @(negedge clk);
        do_reset();

        // Basic: all taps 0.5, sample 0.125 on a cleared line.
        for (int k = 0; k < NTAPS; k++) write_coef(2'(k), 16'sh4000);
        run_sample(16'sh1000, 0, 1'b0, 1'b0, 2'd0, 16'sh0000, got);
        chk16("basic", got, 16'h0800);

        // Positive saturation over four full-scale samples.
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(2'(k), 16'sh7FFF);
        for (int i = 0; i < 4; i++) run_sample(16'sh7FFF, 0, 1'b0, 1'b0, 2'd0, 16'sh0000, got);
        chk16("pos_sat", got, 16'h7FFF);
`ifdef FIR_SEQ_OVF_FLAG_EN
        chk1("pos_sat_ovf", ovf, 1'b1);
`endif

        // Two-sample vectors from the table.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            write_coef(2'd0, vt[i].c0);
            write_coef(2'd1, vt[i].c1);
            run_sample(vt[i].s0, 0, 1'b0, 1'b0, 2'd0, 16'sh0000, got);
            run_sample(vt[i].s1, 0, 1'b0, 1'b0, 2'd0, 16'sh0000, got);
            chk16($sformatf("vec%0d", i), got, vt[i].expv);
        end

        // Backpressure with in_valid held: next result proves the delay line did not move.
        do_reset();
        write_coef(2'd0, 16'sh4000);
        write_coef(2'd1, 16'sh2000);
        run_sample(16'sh2000, 10, 1'b0, 1'b0, 2'd0, 16'sh0000, got);
        chk16("bp_result", got, 16'h1000);
        run_sample(16'sh0000, 0, 1'b0, 1'b0, 2'd0, 16'sh0000, got);
        chk16("bp_line", got, 16'h0800);

        // Coefficient write on the accept edge is used; a write during ACCUM is dropped.
        do_reset();
        run_sample(16'sh4000, 0, 1'b1, 1'b0, 2'd0, 16'sh4000, got);
        chk16("we_accept", got, 16'h2000);
        run_sample(16'sh4000, 0, 1'b0, 1'b1, 2'd0, 16'sh7FFF, got);
        chk16("we_accum_same", got, 16'h2000);
        run_sample(16'sh4000, 0, 1'b0, 1'b0, 2'd0, 16'sh0000, got);
        chk16("we_accum_ignored", got, 16'h2000);

        // Reset mid-ACCUM aborts the result and clears coefficients.
        do_reset();
        write_coef(2'd0, 16'sh4000);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 16'sh4000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk16("midrst_out_data", out_data, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        m_clear();
        seen = 1'b0;
        for (int k = 0; k < NTAPS + 4; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk1("midrst_no_result", seen, 1'b0);
        run_sample(16'sh4000, 0, 1'b0, 1'b0, 2'd0, 16'sh0000, got);
        chk16("midrst_coef_clear", got, 16'h0000);

        // Randomized traffic against the reference model.
        do_reset();
        for (int it = 0; it < 40; it++) begin
            nw = $urandom_range(0, 2);
            for (int j = 0; j < nw; j++) write_coef(2'($urandom_range(0, 3)), rnd16());
            run_sample(rnd16(), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), rnd16(), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 4, number of filter taps (range 2..32).
REQ-002 SHALL have parameter W, default 16, sample and coefficient width; all data is signed Q1.(W-1).
REQ-003 SHALL have port system1000 (input, 1): the single clock; all state updates on its rising edge.
REQ-004 SHALL have port system1000_rst (input, 1): reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid (input, 1): the sample on in_data is offered.
REQ-006 SHALL have port in_data (input, W, signed): the input sample.
REQ-007 SHALL have port in_ready (output, 1): the block accepts a sample this cycle.
REQ-008 SHALL have port coef_we (input, 1): coefficient write strobe.
REQ-009 SHALL have port coef_addr (input, clog2(NTAPS)): index of the coefficient to write.
REQ-010 SHALL have port coef_data (input, W, signed): the coefficient value to write.
REQ-011 SHALL have port out_valid (output, 1): a filter result is available.
REQ-012 SHALL have port out_data (output, W, signed): the saturated filter result.
REQ-013 SHALL have port out_ready (input, 1): the consumer takes the result.

Function
REQ-014 SHALL run an FSM with states IDLE, ACCUM and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 On an IDLE cycle with in_valid=1, the block SHALL:
- shift the delay line (x[k]<=x[k-1], x[0]<=in_data);
- clear acc to 0 and set idx to 0;
- go to ACCUM.
REQ-016 Each ACCUM cycle SHALL compute acc <= sat_add(acc, sat_q(x[idx]*c[idx])) and then set idx <= idx+1.
REQ-017 After the ACCUM cycle with idx==NTAPS-1, the FSM SHALL go to DONE; out_valid rises exactly NTAPS+1 cycles after the accepting edge.
REQ-018 The product SHALL be a full 2W-bit signed value; sat_q is an arithmetic shift right by W-1, saturated to W bits (e.g. 0x8000*0x8000 -> 0x7FFF).
REQ-019 sat_add SHALL be a W-bit signed add that clamps to 0x7FFF when both operands are positive and the sum wraps, and to 0x8000 when both are negative and the sum wraps; otherwise it is the wrapped sum.
REQ-020 In DONE, out_data SHALL equal acc and stay stable until out_ready=1; on that edge the FSM goes to IDLE.
REQ-021 in_valid SHALL be ignored in ACCUM and DONE, and no sample is lost (the source holds it).
REQ-022 coef_we SHALL write c[coef_addr] only in IDLE and is ignored elsewhere.
REQ-023 A coefficient write in the same IDLE cycle as a sample accept SHALL take effect for that sample.
REQ-024 coef_addr >= NTAPS SHALL be ignored.

Reset
REQ-025 While system1000_rst=1, the block SHALL hold:
- state=IDLE, idx=0, acc=0;
- all x[k]=0 and all c[k]=0;
- out_valid=0, out_data=0, in_ready=1.
REQ-026 Reset asserted in ACCUM or DONE SHALL abort the computation; no out_valid follows reset release.

Configuration
REQ-027 With macro FIR_SEQ_OVF_FLAG_EN defined, the block SHALL:
- add output ovf (1 bit), reset 0;
- set ovf sticky on any sat_q or sat_add clamp;
- clear ovf only by reset.
REQ-028 Without FIR_SEQ_OVF_FLAG_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Reset: assert system1000_rst mid-ACCUM -> out_valid=0, in_ready=1, out_data=0 immediately; no result after release.
REQ-030 Basic: all coefficients 0x4000, delay line cleared, accept 0x1000 -> out_valid high 5 cycles later (NTAPS=4) with out_data=0x0800.
REQ-031 Positive saturation: coefficients and samples all 0x7FFF, feed 4 samples -> 4th result 0x7FFF; ovf=1 with the macro defined.
REQ-032 Corner product: c[0]=0x8000, others 0, sample 0x8000 -> out_data=0x7FFF (not 0x8000).
REQ-033 Backpressure: out_ready=0 for 10 cycles with in_valid=1 -> out_data stable, in_ready=0, delay line unchanged; out_ready=1 -> IDLE next cycle.
REQ-034 Coefficient write: coef_we during ACCUM -> coefficient unchanged; coef_we with the accept cycle -> new value used in that result.
